burst_ram: RTL

Burst-oriented RAM sitting directly downstream of the data/instruction caches. It is the memory side of the `br_*` wiring. It accepts one-cycle read/write commands, each moving one cache line as `BURST_DATA_COUNT` consecutive beats of `BURST_DATA_BITWIDTH` bits. It is backed by inferred block RAM, with a programmable read latency and a power-up busy window that mimic the external memory controller.

---
 rtl/burst_ram_pkg.sv | 20 ++
 rtl/burst_ram.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/burst_ram_pkg.sv
// Shared command codes and FSM encodings for the burst RAM and the caches that drive it.
package burst_ram_pkg;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  typedef enum logic [4:0] {
    ST_INIT      = 5'b00001,
    ST_IDLE      = 5'b00010,
    ST_WRITE     = 5'b00100,
    ST_READ_WAIT = 5'b01000,
    ST_READ      = 5'b10000
  } state_t;

  // Counter widths must stay at least one bit even for degenerate parameters.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/burst_ram.sv
// Burst RAM behind the caches: one command moves BURST_DATA_COUNT beats; first read beat READ_LATENCY cycles after the command.
// No backpressure: busy flags the cycles in which cmd_en is dropped (init window and every burst in flight).
module burst_ram
  import burst_ram_pkg::*;
#(
  parameter int    BURST_DATA_BITWIDTH = 64,
  parameter int    BURST_DATA_COUNT    = 4,
  parameter int    DEPTH_BITWIDTH      = 8,
  parameter int    READ_LATENCY        = 3,
  parameter int    INIT_CYCLES         = 8,
  parameter string DATA_FILE           = ""
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cmd,
  input  logic                             cmd_en,
  input  logic [DEPTH_BITWIDTH-1:0]        addr,
  input  logic [BURST_DATA_BITWIDTH-1:0]   wr_data,
  input  logic [BURST_DATA_BITWIDTH/8-1:0] data_mask,
  output logic [BURST_DATA_BITWIDTH-1:0]   rd_data,
  output logic                             rd_data_valid,
  output logic                             busy
);

  localparam int BYTES  = BURST_DATA_BITWIDTH / 8;
  localparam int BEAT_W = clog2_min1(BURST_DATA_COUNT);
  localparam int INIT_W = clog2_min1(INIT_CYCLES + 1);

  localparam logic [BEAT_W-1:0]         BEAT_LAST = BEAT_W'(BURST_DATA_COUNT - 1);
  localparam logic [INIT_W-1:0]         INIT_LAST = INIT_W'(INIT_CYCLES - 1);
  localparam logic [DEPTH_BITWIDTH-1:0] GRP_MASK  = DEPTH_BITWIDTH'(BURST_DATA_COUNT - 1);

  logic [BURST_DATA_BITWIDTH-1:0] r_mem [0:(1<<DEPTH_BITWIDTH)-1];

  state_t                    r_state, w_state_nxt;
  logic [BEAT_W-1:0]         r_beat, w_beat_nxt;
  logic [3:0]                r_lat, w_lat_nxt;
  logic [INIT_W-1:0]         r_init_cnt, w_init_nxt;
  logic [DEPTH_BITWIDTH-1:0] r_base, w_base_nxt;
  logic                      r_rd_valid;

  logic [DEPTH_BITWIDTH-1:0] w_base;
  logic [DEPTH_BITWIDTH-1:0] w_mem_addr;
  logic                      w_accept;
  logic                      w_we;
  logic                      w_rd_fire;

  assign w_base = addr & ~GRP_MASK;

  // The last read beat is still on the output while the FSM is already IDLE, so it counts as busy.
  assign w_accept  = cmd_en && (r_state == ST_IDLE) && !r_rd_valid;
  assign w_we      = !rst && ((w_accept && cmd == CMD_WRITE) || r_state == ST_WRITE);
  assign w_rd_fire = !rst && ((w_accept && cmd == CMD_READ && READ_LATENCY == 1) ||
                              r_state == ST_READ);

  // Beat 0 of either command uses the live address; later beats use the latched base.
  assign w_mem_addr = (r_state == ST_WRITE || r_state == ST_READ)
                    ? (r_base | DEPTH_BITWIDTH'(r_beat)) : w_base;

  assign busy          = (r_state != ST_IDLE) || r_rd_valid;
  assign rd_data_valid = r_rd_valid;

  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int b = 0; b < BYTES; b++) begin
        if (!data_mask[b]) begin
          r_mem[w_mem_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
        end
      end
    end
  end

  // The read is issued one cycle ahead so the registered output lands on the target cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data    <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_fire;
      if (w_rd_fire) begin
        rd_data <= r_mem[w_mem_addr];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= (INIT_CYCLES > 0) ? ST_INIT : ST_IDLE;
      r_beat     <= '0;
      r_lat      <= '0;
      r_init_cnt <= '0;
      r_base     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_beat     <= w_beat_nxt;
      r_lat      <= w_lat_nxt;
      r_init_cnt <= w_init_nxt;
      r_base     <= w_base_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat;
    w_lat_nxt   = r_lat;
    w_init_nxt  = r_init_cnt;
    w_base_nxt  = r_base;

    case (r_state)
      ST_INIT: begin
        if (r_init_cnt == INIT_LAST) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_init_nxt = r_init_cnt + INIT_W'(1);
        end
      end

      ST_IDLE: begin
        if (w_accept) begin
          w_base_nxt = w_base;
          if (cmd == CMD_WRITE) begin
            w_beat_nxt  = BEAT_W'(1);
            w_state_nxt = (BURST_DATA_COUNT == 1) ? ST_IDLE : ST_WRITE;
          end else if (READ_LATENCY == 1) begin
            w_beat_nxt  = BEAT_W'(1);
            w_state_nxt = (BURST_DATA_COUNT == 1) ? ST_IDLE : ST_READ;
          end else if (READ_LATENCY == 2) begin
            w_beat_nxt  = '0;
            w_state_nxt = ST_READ;
          end else begin
            w_beat_nxt  = '0;
            w_lat_nxt   = 4'(READ_LATENCY - 2);
            w_state_nxt = ST_READ_WAIT;
          end
        end
      end

      ST_WRITE, ST_READ: begin
        w_beat_nxt = r_beat + BEAT_W'(1);
        if (r_beat == BEAT_LAST) begin
          w_state_nxt = ST_IDLE;
        end
      end

      ST_READ_WAIT: begin
        if (r_lat == 4'd1) begin
          w_state_nxt = ST_READ;
        end else begin
          w_lat_nxt = r_lat - 4'd1;
        end
      end

      default: w_state_nxt = ST_INIT;
    endcase
  end

endmodule
